// File: rtl/axis_checker_pkg.sv
// axis_checker_pkg: shared FSM state type and lane-vector helpers for the stream checker
package axis_checker_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, TOUT = 2'd3} state_e;
    localparam int MAX_LANES = 64;
    function automatic logic [7:0] popcount(input logic [MAX_LANES-1:0] v);
        popcount = '0;
        for (int i = 0; i < MAX_LANES; i++) popcount += 8'(v[i]);
    endfunction
    function automatic logic [7:0] lowest_set(input logic [MAX_LANES-1:0] v);
        lowest_set = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) if (v[i]) lowest_set = 8'(i);
    endfunction
endpackage

// File: rtl/axis_multi_checker_if.sv
// axis_multi_checker_if: DUT-output and expected-data AXI-Stream bundles, all channels packed
interface axis_multi_checker_if #(parameter int N_CH = 2, parameter int W = 64);
    logic [N_CH*W-1:0]   s_out_tdata, s_exp_tdata;
    logic [N_CH*W/8-1:0] s_out_tkeep, s_exp_tkeep;
    logic [N_CH-1:0]     s_out_tlast, s_out_tvalid, s_out_tready;
    logic [N_CH-1:0]     s_exp_tlast, s_exp_tvalid, s_exp_tready;
    modport master (output s_out_tdata, s_out_tkeep, s_out_tlast, s_out_tvalid,
                    output s_exp_tdata, s_exp_tkeep, s_exp_tlast, s_exp_tvalid,
                    input s_out_tready, s_exp_tready);
    modport slave (input s_out_tdata, s_out_tkeep, s_out_tlast, s_out_tvalid,
                   input s_exp_tdata, s_exp_tkeep, s_exp_tlast, s_exp_tvalid,
                   output s_out_tready, s_exp_tready);
endinterface

// File: rtl/axis_checker_lane.sv
// axis_checker_lane: one channel's lockstep join, byte compare, error stats and length check
module axis_checker_lane
    import axis_checker_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             run,
    input  logic [W-1:0]     out_tdata,
    input  logic [W/8-1:0]   out_tkeep,
    input  logic             out_tlast,
    input  logic             out_tvalid,
    input  logic [W-1:0]     exp_tdata,
    input  logic [W/8-1:0]   exp_tkeep,
    input  logic             exp_tlast,
    input  logic             exp_tvalid,
    output logic             out_tready,
    output logic             exp_tready,
    output logic             fire,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [7:0]       first_exp,
    output logic [7:0]       first_got,
    output logic             len_err,
    output logic             ch_done
);
    localparam int NB = W / 8;
    logic            active, got_first;
    logic [NB-1:0]   mis, below;
    logic [7:0]      lo, fe, fg;
    logic [CNT_W:0]  sum;
    logic [CNT_W-1:0] idx;
    // Each ready follows the other side's valid only, so the join never deadlocks
    always_comb begin
        active     = run & ~ch_done;
        out_tready = active & exp_tvalid;
        exp_tready = active & out_tvalid;
        fire       = active & out_tvalid & exp_tvalid;
        for (int i = 0; i < NB; i++)
            mis[i] = exp_tkeep[i] & (~out_tkeep[i] | (out_tdata[8*i +: 8] != exp_tdata[8*i +: 8]));
        lo = lowest_set(MAX_LANES'(mis));
        fe = '0;
        fg = '0;
        for (int i = 0; i < NB; i++) begin
            below[i] = exp_tkeep[i] & (8'(i) < lo);
            fe = (8'(i) == lo) ? exp_tdata[8*i +: 8] : fe;
            fg = (8'(i) == lo) ? out_tdata[8*i +: 8] : fg;
        end
        sum = {1'b0, err_cnt} + (CNT_W+1)'(popcount(MAX_LANES'(mis)));
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || clr) begin
            idx       <= '0;
            err_cnt   <= '0;
            first_idx <= '0;
            first_exp <= '0;
            first_got <= '0;
            got_first <= 1'b0;
            len_err   <= 1'b0;
            ch_done   <= 1'b0;
        end else if (fire) begin
            idx     <= idx + CNT_W'(popcount(MAX_LANES'(exp_tkeep)));
            err_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            if (|mis && !got_first) begin
                got_first <= 1'b1;
                first_idx <= idx + CNT_W'(popcount(MAX_LANES'(below)));
                first_exp <= fe;
                first_got <= fg;
            end
            if (out_tlast != exp_tlast) len_err <= 1'b1;
            if (exp_tlast) ch_done <= 1'b1;
        end
    end
endmodule

// File: rtl/axis_multi_checker.sv
// axis_multi_checker: N-channel stream result checker with run FSM, no-progress watchdog
// and global done/pass reduction over per-channel lanes.
module axis_multi_checker
    import axis_checker_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int W           = 64,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    axis_multi_checker_if.slave   axis,
    output logic [N_CH*CNT_W-1:0] err_cnt,
    output logic [N_CH*CNT_W-1:0] first_idx,
    output logic [N_CH*8-1:0]     first_exp,
    output logic [N_CH*8-1:0]     first_got,
    output logic [N_CH-1:0]       len_err,
    output logic [N_CH-1:0]       ch_done,
    output logic                  timeout,
    output logic                  done,
    output logic                  pass
);
    state_e          state, nxt;
    logic [N_CH-1:0] fire, err_nz;
    logic [31:0]     wd;
    logic            run, wd_exp, all_ok;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        axis_checker_lane #(.W(W), .CNT_W(CNT_W)) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .clr        (start),
            .run        (run),
            .out_tdata  (axis.s_out_tdata[c*W +: W]),
            .out_tkeep  (axis.s_out_tkeep[c*W/8 +: W/8]),
            .out_tlast  (axis.s_out_tlast[c]),
            .out_tvalid (axis.s_out_tvalid[c]),
            .exp_tdata  (axis.s_exp_tdata[c*W +: W]),
            .exp_tkeep  (axis.s_exp_tkeep[c*W/8 +: W/8]),
            .exp_tlast  (axis.s_exp_tlast[c]),
            .exp_tvalid (axis.s_exp_tvalid[c]),
            .out_tready (axis.s_out_tready[c]),
            .exp_tready (axis.s_exp_tready[c]),
            .fire       (fire[c]),
            .err_cnt    (err_cnt[c*CNT_W +: CNT_W]),
            .first_idx  (first_idx[c*CNT_W +: CNT_W]),
            .first_exp  (first_exp[c*8 +: 8]),
            .first_got  (first_got[c*8 +: 8]),
            .len_err    (len_err[c]),
            .ch_done    (ch_done[c])
        );
        assign err_nz[c] = |err_cnt[c*CNT_W +: CNT_W];
    end
    // A beat in the expiry cycle keeps the run alive; start blocks fires so no beat is lost to the clear
    always_comb begin
        run     = (state == RUN) & ~start;
        wd_exp  = (TIMEOUT_CYC != 0) && !(|fire) && (wd == 32'(TIMEOUT_CYC - 1));
        nxt     = start ? RUN : (state == RUN) ? (&ch_done ? DONE : wd_exp ? TOUT : RUN) : state;
        done    = (state == DONE) || (state == TOUT);
        timeout = state == TOUT;
        all_ok  = ~|err_nz & ~|len_err;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            wd    <= '0;
            pass  <= 1'b0;
        end else begin
            state <= nxt;
            wd    <= (run && !(|fire)) ? wd + 32'd1 : '0;
            pass  <= (nxt == DONE) && all_ok;
        end
    end
endmodule

// File: tb/tb_axis_multi_checker.sv
// tb_axis_multi_checker: scoreboard bench; a byte-level model predicts each run's statistics
module tb_axis_multi_checker;
    logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
    always #5 clk = ~clk;
    axis_multi_checker_if #(.N_CH(2), .W(64)) bus ();
    logic [63:0] err_cnt, first_idx;
    logic [15:0] first_exp, first_got;
    logic [1:0]  len_err, ch_done;
    logic        timeout, done, pass;
    axis_multi_checker #(.N_CH(2), .W(64), .CNT_W(32), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rstn(rstn), .start(start), .axis(bus),
        .err_cnt(err_cnt), .first_idx(first_idx), .first_exp(first_exp), .first_got(first_got),
        .len_err(len_err), .ch_done(ch_done), .timeout(timeout), .done(done), .pass(pass)
    );
    typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
    typedef struct packed {
        logic [1:0][31:0] err, fidx;
        logic [1:0][7:0]  fexp, fgot;
        logic [1:0]       len, chd;
        logic             tmo, pass;
    } res_t;
    beat_t oq[2][$];
    beat_t eq[2][$];
    res_t  sbq[$];
    int n_chk = 0, n_pass = 0, idle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build_same(input int n);
        beat_t b;
        for (int c = 0; c < 2; c++) begin
            oq[c].delete();
            eq[c].delete();
            for (int j = 0; j < n; j++) begin
                b.d = {32'(c * 1000 + j), 32'hC0DE0000 | 32'(j * 7 + 1)};
                b.k = 8'hFF;
                b.l = (j == n - 1);
                oq[c].push_back(b);
                eq[c].push_back(b);
            end
        end
    endtask

    function automatic res_t model();
        res_t r;
        beat_t o, e;
        int idx, n;
        bit got, fin;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            idx = 0;
            got = 0;
            fin = 0;
            n = oq[c].size() < eq[c].size() ? oq[c].size() : eq[c].size();
            for (int j = 0; j < n && !fin; j++) begin
                o = oq[c][j];
                e = eq[c][j];
                for (int i = 0; i < 8; i++) if (e.k[i]) begin
                    if (!o.k[i] || o.d[8*i +: 8] != e.d[8*i +: 8]) begin
                        r.err[c] = r.err[c] + 32'd1;
                        if (!got) begin
                            got = 1;
                            r.fidx[c] = 32'(idx);
                            r.fexp[c] = e.d[8*i +: 8];
                            r.fgot[c] = o.d[8*i +: 8];
                        end
                    end
                    idx++;
                end
                if (o.l != e.l) r.len[c] = 1'b1;
                if (e.l) fin = 1;
            end
            r.chd[c] = fin;
        end
        r.tmo  = !(&r.chd);
        r.pass = !r.tmo && r.err == '0 && r.len == '0;
        return r;
    endfunction

    task automatic run(input int rate, input int budget, input bit need_fin, output int idl);
        bit of[2], ef[2], fin;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("clr_err", err_cnt, 0);
        check("clr_done", done, 0);
        of = '{0, 0};
        ef = '{0, 0};
        idl = 0;
        fin = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (of[c]) void'(oq[c].pop_front());
                if (ef[c]) void'(eq[c].pop_front());
            end
            idl = (of[0] | of[1]) ? 0 : idl + 1;
            if (done) begin
                fin = 1;
                break;
            end
            for (int c = 0; c < 2; c++) begin
                if (!bus.s_out_tvalid[c] || of[c]) begin
                    bus.s_out_tvalid[c] = oq[c].size() > 0 && $urandom_range(99) < rate;
                    if (bus.s_out_tvalid[c]) begin
                        bus.s_out_tdata[c*64 +: 64] = oq[c][0].d;
                        bus.s_out_tkeep[c*8 +: 8]   = oq[c][0].k;
                        bus.s_out_tlast[c]          = oq[c][0].l;
                    end
                end
                if (!bus.s_exp_tvalid[c] || ef[c]) begin
                    bus.s_exp_tvalid[c] = eq[c].size() > 0 && $urandom_range(99) < rate;
                    if (bus.s_exp_tvalid[c]) begin
                        bus.s_exp_tdata[c*64 +: 64] = eq[c][0].d;
                        bus.s_exp_tkeep[c*8 +: 8]   = eq[c][0].k;
                        bus.s_exp_tlast[c]          = eq[c][0].l;
                    end
                end
            end
            #3;
            for (int c = 0; c < 2; c++) begin
                of[c] = bus.s_out_tvalid[c] & bus.s_out_tready[c];
                ef[c] = bus.s_exp_tvalid[c] & bus.s_exp_tready[c];
            end
            @(negedge clk);
        end
        if (need_fin) check("finished", fin, 1);
        if (fin) begin
            bus.s_out_tvalid = '0;
            bus.s_exp_tvalid = '0;
        end
    endtask

    task automatic verify(input int idl);
        res_t r;
        r = sbq.pop_front();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("err_cnt%0d", c), err_cnt[c*32 +: 32], r.err[c]);
            check($sformatf("first_idx%0d", c), first_idx[c*32 +: 32], r.fidx[c]);
            check($sformatf("first_exp%0d", c), first_exp[c*8 +: 8], r.fexp[c]);
            check($sformatf("first_got%0d", c), first_got[c*8 +: 8], r.fgot[c]);
        end
        check("len_err", len_err, r.len);
        check("ch_done", ch_done, r.chd);
        check("timeout", timeout, r.tmo);
        check("done", done, 1);
        check("pass", pass, r.pass);
        check("rdy_idle", {bus.s_out_tready, bus.s_exp_tready}, 0);
        if (r.tmo) check("idle_cycles", idl, 50);
    endtask

    task automatic set_byte(input bit out_side, input int c, input int j, input int lane, input logic [7:0] v);
        beat_t b;
        b = out_side ? oq[c][j] : eq[c][j];
        b.d[8*lane +: 8] = v;
        if (out_side) oq[c][j] = b;
        else eq[c][j] = b;
    endtask

    initial begin
        beat_t b;
        bus.s_out_tdata = '0; bus.s_out_tkeep = '0; bus.s_out_tlast = '0; bus.s_out_tvalid = '0;
        bus.s_exp_tdata = '0; bus.s_exp_tkeep = '0; bus.s_exp_tlast = '0; bus.s_exp_tvalid = '0;
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err", err_cnt, 0);
        check("rst_rdy", {bus.s_out_tready, bus.s_exp_tready}, 0);
        rstn = 1'b1;
        // identical streams
        build_same(16);
        sbq.push_back(model());
        run(100, 200, 1, idle);
        verify(idle);
        check("t1_pass", pass, 1);
        // single corrupted byte on channel 1
        build_same(16);
        set_byte(0, 1, 3, 5, 8'hA5);
        set_byte(1, 1, 3, 5, 8'h5A);
        sbq.push_back(model());
        run(100, 200, 1, idle);
        verify(idle);
        check("t2_idx", first_idx[63:32], 29);
        // partial keep on final beat
        build_same(16);
        b = eq[0][15]; b.k = 8'h0F; eq[0][15] = b;
        b = oq[0][15]; b.k = 8'h07; oq[0][15] = b;
        sbq.push_back(model());
        run(100, 200, 1, idle);
        verify(idle);
        check("t3_err", err_cnt[31:0], 1);
        // early tlast from DUT
        build_same(8);
        b = oq[0][6]; b.l = 1'b1; oq[0][6] = b;
        b = oq[0][7]; b.l = 1'b0; oq[0][7] = b;
        sbq.push_back(model());
        run(100, 200, 1, idle);
        verify(idle);
        // channel 0 stalls after two beats
        build_same(16);
        while (oq[0].size() > 2) void'(oq[0].pop_back());
        sbq.push_back(model());
        run(100, 300, 1, idle);
        verify(idle);
        // asynchronous reset mid-run
        build_same(16);
        set_byte(0, 0, 0, 0, 8'h00);
        run(100, 4, 0, idle);
        check("pre_rst_err", err_cnt[31:0], 1);
        check("pre_rst_rdy", bus.s_out_tready, 2'b11);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rdy", {bus.s_out_tready, bus.s_exp_tready}, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_first", {first_idx, first_exp, first_got}, 0);
        check("mid_rst_flags", {ch_done, len_err, done, pass, timeout}, 0);
        bus.s_out_tvalid = '0;
        bus.s_exp_tvalid = '0;
        @(negedge clk) rstn = 1'b1;
        // throttled runs; the second start lands in DONE and must clear the error state
        build_same(16);
        set_byte(0, 1, 3, 5, 8'hA5);
        set_byte(1, 1, 3, 5, 8'h5A);
        sbq.push_back(model());
        run(50, 2000, 1, idle);
        verify(idle);
        build_same(16);
        sbq.push_back(model());
        run(50, 2000, 1, idle);
        verify(idle);
        check("t6_pass", pass, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_multi_checker.md
Name: axis_multi_checker

Overview:
- Synthesizable N-channel AXI-Stream result checker that compares DUT output streams against expected-data streams.
- Replaces the bench-level byte-compare loop so the same pass/fail logic runs in simulation and on FPGA.
- Sits between the accelerator output path (or DMA read-back) and an expected-data source.
- Reports per-channel mismatch counts, first-mismatch index and data, length errors, a no-progress timeout, and global done/pass.

Parameters:
- N_CH, 2, number of independent compare channels.
- W, 64, stream data width in bits; multiple of 8.
- CNT_W, 32, width of byte-index and mismatch counters.
- TIMEOUT_CYC, 100000, cycles without any accepted beat on any unfinished channel before timeout; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  pulse; clears all state and arms every channel.
- s_out_tdata  in  N_CH*W  DUT output data, channel c at [c*W +: W].
- s_out_tkeep  in  N_CH*W/8  DUT byte enables.
- s_out_tlast  in  N_CH  DUT end-of-stream.
- s_out_tvalid  in  N_CH  DUT valid.
- s_out_tready  out  N_CH  ready to DUT.
- s_exp_tdata / s_exp_tkeep / s_exp_tlast / s_exp_tvalid  in  same widths  expected stream.
- s_exp_tready  out  N_CH  ready to expected source.
- err_cnt  out  N_CH*CNT_W  mismatched-byte count per channel (saturating).
- first_idx  out  N_CH*CNT_W  byte index of first mismatch.
- first_exp / first_got  out  N_CH*8  bytes at first mismatch.
- len_err  out  N_CH  tlast disagreement seen.
- ch_done  out  N_CH  channel finished.
- timeout  out  1  watchdog fired.
- done  out  1  all channels done or timeout.
- pass  out  1  valid when done: no errors, no len_err, no timeout.

Behaviour:
- Reset (rstn low, asynchronous):
  - FSM goes to IDLE.
  - Both readies are 0.
  - All counters, first_* and flags are 0; done=0, pass=0, timeout=0.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: all ch_done -> DONE; watchdog expiry -> TOUT.
  - DONE, TOUT: start -> RUN.
  - start in any state re-clears all channel state and enters RUN on the next cycle.
  - done=1 in DONE and TOUT; timeout=1 only in TOUT.
  - pass = done & ~timeout & all err_cnt==0 & no len_err; registered.
- Handshake, per channel, in RUN and not ch_done:
  - s_out_tready[c] = s_exp_tvalid[c]; s_exp_tready[c] = s_out_tvalid[c].
  - The two streams advance in lockstep; a beat fires when both valids are high.
  - Readies do not depend combinationally on their own valid, so the join is deadlock-free.
  - Outside RUN, or once ch_done[c]=1, both readies are 0.
- Compare, per fired beat:
  - For each byte lane i where exp_tkeep[i]=1, the byte mismatches if out_tkeep[i]=0 or the data bytes differ.
  - Lanes with exp_tkeep=0 are ignored.
  - err_cnt adds the popcount of mismatching lanes and saturates at all-ones.
  - Byte index advances by popcount(exp_tkeep); the index is wrapping CNT_W.
- First mismatch is latched once per run and holds until the next start:
  - first_idx = beat base index + count of kept lanes below the lowest mismatching lane.
  - first_exp / first_got hold that lane's bytes.
- Length check:
  - exp_tlast=1 on a fired beat sets ch_done.
  - out_tlast != exp_tlast on a fired beat sets len_err; the channel still ends on exp_tlast.
- Watchdog:
  - Counts cycles in RUN with no fired beat on any channel; resets to 0 on any fire.
  - Reaching TIMEOUT_CYC enters TOUT.
  - A beat firing in the same cycle as expiry wins: the counter clears and there is no timeout.
- Latency: statistics update 1 cycle after the fire; done/pass assert 1 cycle after the last ch_done.

Decomposition:
- Package axis_checker_pkg:
  - FSM state enum {IDLE, RUN, DONE, TOUT}.
  - Function popcount(W/8).
  - Function lowest_set index.
- Sub-module axis_checker_lane, one instance per channel, generated:
  - Holds the join handshake, byte compare, counters, first-mismatch capture and len_err.
- The top holds the FSM, the watchdog and the done/pass reduction.

Test Plan:
- W=64, N_CH=2: start, then 16 identical full beats per channel with tlast on beat 16 -> err_cnt=0, ch_done=11, done=1, pass=1.
- Channel 1 beat 3 byte 5: exp 0xA5, got 0x5A; all else identical -> err_cnt[1]=1, first_idx[1]=29, first_exp=0xA5, first_got=0x5A, pass=0.
- Final beat exp_tkeep=0x0F, out_tkeep=0x07, data equal -> err_cnt=1 (lane 3); lanes 4-7 ignored.
- DUT asserts tlast on beat 7, expected stream on beat 8 -> len_err=1, ch_done on beat 8, pass=0.
- TIMEOUT_CYC=50, channel 0 stalls out_tvalid after 2 beats -> timeout=1 and done=1 after 50 idle cycles, pass=0; assert rstn low mid-run -> all outputs 0 immediately.
- Random valid/tvalid throttling at 50%, then start re-issued in DONE -> counters cleared, second identical run gives pass=1.
